serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have parameter CMD_BITS, default 8, CMD field width.
REQ-002 SHALL have parameter ADDR_BITS, default 4, ADDR field width.
REQ-003 SHALL have parameter EOF_BITS, default 2, EOF field width (all ones).
REQ-004 SHALL have parameter BIT_CYCLES, default 1, clocks per serial bit (>=1).
REQ-005 SHALL have parameter GAP_BITS, default 1, idle-high bit periods after EOF before next accept (>=0).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid  input  1  frame request valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a frame.
REQ-010 SHALL have port in_cmd  input  CMD_BITS  command payload.
REQ-011 SHALL have port in_addr  input  ADDR_BITS  address payload.
REQ-012 SHALL have port tx_out  output  1  serial line, idles high.
REQ-013 SHALL have port busy  output  1  high from accept until gap ends.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of last EOF bit.

Function
REQ-015 Frame SHALL be: SOP (1 bit, 0), CMD (LSB first), ADDR (LSB first), EOF (EOF_BITS ones).
REQ-016 FSM states SHALL be IDLE, SOP, CMD, ADDR, EOF, GAP; IDLE->SOP on accept, each field state advances after its last bit period, EOF->GAP (or IDLE if GAP_BITS=0), GAP->IDLE after GAP_BITS periods.
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready; in_cmd/in_addr latched into internal shift registers at that edge.
REQ-018 in_ready SHALL be high only in IDLE; registered, not combinationally dependent on in_valid.
REQ-019 tx_out SHALL be a registered output; SOP bit drives it in the first cycle after accept.
REQ-020 Each bit SHALL be held exactly BIT_CYCLES cycles; a frame occupies (1+CMD_BITS+ADDR_BITS+EOF_BITS)*BIT_CYCLES cycles.
REQ-021 tx_out SHALL be 1 in IDLE, EOF and GAP.
REQ-022 done SHALL pulse high in the final cycle of the last EOF bit; never otherwise.
REQ-023 busy SHALL equal !IDLE (registered state); in_valid and payload changes while busy SHALL be ignored.
REQ-024 With in_valid held high, next accept SHALL occur in the first IDLE cycle: back-to-back frames separated by exactly GAP_BITS*BIT_CYCLES idle-high cycles plus one IDLE cycle.
REQ-025 Bit-period and bit-index counters SHALL be sized $clog2 of their max value+1 and wrap to 0 at each bit/field boundary with no overflow.

Reset
REQ-026 While rst=0: state IDLE, tx_out=1, in_ready=0, busy=0, done=0, counters and shift registers 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately (asynchronously): tx_out high, no done pulse, payload discarded.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-029 Package serial_frame_pkg SHALL hold the FSM state enum and default field-width constants, shared with the frame receiver.
REQ-030 Sub-module serial_bit_timer SHALL generate the bit-period tick from BIT_CYCLES; the FSM and shift logic live in serial_frame_tx.

Verification
REQ-031 BIT_CYCLES=1, cmd=8'hA5, addr=4'h3 -> tx_out from cycle after accept: 0,1,0,1,0,0,1,0,1,1,1,0,0,1,1; done on the 15th bit cycle.
REQ-032 BIT_CYCLES=4, same payload -> each bit held 4 cycles, frame 60 cycles, done in cycle 60 only.
REQ-033 in_valid held high, frames 8'h01/4'h1 then 8'hFF/4'h0, GAP_BITS=1 -> second SOP starts exactly 2 cycles after first frame's last EOF cycle; payload bits correct.
REQ-034 rst pulled low during 3rd CMD bit -> tx_out=1 same cycle, busy=0, no done; next accepted frame transmitted intact.
REQ-035 in_valid pulsed with new payload mid-frame -> ignored; in_ready stays 0; transmitted bits match original payload.
REQ-036 Receiver loopback: 100 random cmd/addr frames -> receiver decodes identical CMD/ADDR values.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and receiver.
package serial_frame_pkg;

   localparam int unsigned DEF_CMD_BITS   = 8;
   localparam int unsigned DEF_ADDR_BITS  = 4;
   localparam int unsigned DEF_EOF_BITS   = 2;
   localparam int unsigned DEF_BIT_CYCLES = 1;
   localparam int unsigned DEF_GAP_BITS   = 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SOP  = 3'd1;
   localparam logic [2:0] ST_CMD  = 3'd2;
   localparam logic [2:0] ST_ADDR = 3'd3;
   localparam logic [2:0] ST_EOF  = 3'd4;
   localparam logic [2:0] ST_GAP  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_SOP  = ST_SOP,
      S_CMD  = ST_CMD,
      S_ADDR = ST_ADDR,
      S_EOF  = ST_EOF,
      S_GAP  = ST_GAP
   } frame_state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick marks the last clock of each serial bit period.
module serial_bit_timer
   import serial_frame_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = cnt_width(BIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = run && (cnt_q == CW'(BIT_CYCLES - 1));

   // Count clocks within a bit; hold at zero while idle so each frame starts aligned.
   always_comb begin
      cnt_d = '0;
      if (run && !tick) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Period counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: SOP(0), CMD LSB-first, ADDR LSB-first, EOF ones, idle gap.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int unsigned CMD_BITS   = DEF_CMD_BITS,
   parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
   parameter int unsigned EOF_BITS   = DEF_EOF_BITS,
   parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
   parameter int unsigned GAP_BITS   = DEF_GAP_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CMD_BITS-1:0]  in_cmd,
   input  logic [ADDR_BITS-1:0] in_addr,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned IDX_MAX  = max2(max2(CMD_BITS, ADDR_BITS), max2(EOF_BITS, GAP_BITS)) - 1;
   localparam int unsigned IW       = cnt_width(IDX_MAX);
   localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

   logic [2:0]           state_q,    state_d;
   logic [IW-1:0]        bit_idx_q,  bit_idx_d;
   logic [CMD_BITS-1:0]  cmd_sh_q,   cmd_sh_d;
   logic [ADDR_BITS-1:0] addr_sh_q,  addr_sh_d;
   logic                 tx_out_q,   tx_out_d;
   logic                 in_ready_q, in_ready_d;
   logic                 tick;

   serial_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (state_q != ST_IDLE),
      .tick (tick)
   );

   assign tx_out   = tx_out_q;
   assign in_ready = in_ready_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_EOF) && tick && (bit_idx_q == IW'(EOF_BITS - 1));

   // Frame sequencing; tx_out_d is the value the line takes for the next bit period,
   // so bit 0 of each shift register is always the bit about to go out.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      cmd_sh_d  = cmd_sh_q;
      addr_sh_d = addr_sh_q;
      tx_out_d  = tx_out_q;
      case (state_q)
         ST_IDLE: begin
            tx_out_d = 1'b1;
            if (in_valid && in_ready_q) begin
               state_d   = ST_SOP;
               bit_idx_d = '0;
               cmd_sh_d  = in_cmd;
               addr_sh_d = in_addr;
               tx_out_d  = 1'b0;
            end
         end
         ST_SOP: begin
            if (tick) begin
               state_d  = ST_CMD;
               tx_out_d = cmd_sh_q[0];
            end
         end
         ST_CMD: begin
            if (tick) begin
               if (bit_idx_q == IW'(CMD_BITS - 1)) begin
                  state_d   = ST_ADDR;
                  bit_idx_d = '0;
                  tx_out_d  = addr_sh_q[0];
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
                  cmd_sh_d  = cmd_sh_q >> 1;
                  tx_out_d  = cmd_sh_d[0];
               end
            end
         end
         ST_ADDR: begin
            if (tick) begin
               if (bit_idx_q == IW'(ADDR_BITS - 1)) begin
                  state_d   = ST_EOF;
                  bit_idx_d = '0;
                  tx_out_d  = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
                  addr_sh_d = addr_sh_q >> 1;
                  tx_out_d  = addr_sh_d[0];
               end
            end
         end
         ST_EOF: begin
            tx_out_d = 1'b1;
            if (tick) begin
               if (bit_idx_q == IW'(EOF_BITS - 1)) begin
                  state_d   = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
               end
            end
         end
         ST_GAP: begin
            tx_out_d = 1'b1;
            if (tick) begin
               if (bit_idx_q == IW'(GAP_LAST)) begin
                  state_d   = ST_IDLE;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_idx_d = '0;
            tx_out_d  = 1'b1;
         end
      endcase
   end

   // Ready is registered from the next state, so it is high exactly in IDLE cycles
   // (except the first one after reset) and never follows in_valid combinationally.
   always_comb begin
      in_ready_d = (state_d == ST_IDLE);
   end

   // State, shift and line registers; reset aborts any frame with the line high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         bit_idx_q  <= '0;
         cmd_sh_q   <= '0;
         addr_sh_q  <= '0;
         tx_out_q   <= 1'b1;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         cmd_sh_q   <= cmd_sh_d;
         addr_sh_q  <= addr_sh_d;
         tx_out_q   <= tx_out_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx at BIT_CYCLES=1 and BIT_CYCLES=4.
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       drv_valid = 1'b0;
   logic       sel4 = 1'b0;
   logic [7:0] drv_cmd = '0;
   logic [3:0] drv_addr = '0;

   logic v1, v4, rdy1, rdy4, tx1, tx4, busy1, busy4, done1, done4;
   logic tx_o, rdy_o, busy_o, done_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign v1     = drv_valid & ~sel4;
   assign v4     = drv_valid & sel4;
   assign tx_o   = sel4 ? tx4   : tx1;
   assign rdy_o  = sel4 ? rdy4  : rdy1;
   assign busy_o = sel4 ? busy4 : busy1;
   assign done_o = sel4 ? done4 : done1;

   serial_frame_tx #(
      .CMD_BITS (8), .ADDR_BITS (4), .EOF_BITS (2), .BIT_CYCLES (1), .GAP_BITS (1)
   ) u_dut1 (
      .clk (clk), .rst (rst), .in_valid (v1), .in_ready (rdy1),
      .in_cmd (drv_cmd), .in_addr (drv_addr),
      .tx_out (tx1), .busy (busy1), .done (done1)
   );

   serial_frame_tx #(
      .CMD_BITS (8), .ADDR_BITS (4), .EOF_BITS (2), .BIT_CYCLES (4), .GAP_BITS (1)
   ) u_dut4 (
      .clk (clk), .rst (rst), .in_valid (v4), .in_ready (rdy4),
      .in_cmd (drv_cmd), .in_addr (drv_addr),
      .tx_out (tx4), .busy (busy4), .done (done4)
   );

   // Line order: bit 0 is SOP, then CMD LSB first, ADDR LSB first, two EOF ones.
   function automatic logic [14:0] frame_bits(input logic [7:0] c, input logic [3:0] a);
      return {2'b11, a, c, 1'b0};
   endfunction

   task automatic wait_ready(input string tag);
      int unsigned n;
      n = 0;
      while (rdy_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rdy_o !== 1'b1) begin
         failures++;
         $display("FAIL %s_ready_timeout: in_ready=%b required 1", tag, rdy_o);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx1, rdy1, busy1, done1} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_dut1: tx/rdy/busy/done=%b required 1000", {tx1, rdy1, busy1, done1});
      end
      checks++;
      if ({tx4, rdy4, busy4, done4} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_dut4: tx/rdy/busy/done=%b required 1000", {tx4, rdy4, busy4, done4});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rdy1, rdy4} !== 2'b11) begin
         failures++;
         $display("FAIL ready_after_reset: rdy1/rdy4=%b required 11", {rdy1, rdy4});
      end
   endtask

   // One frame; optional mid-frame in_valid pulse with a different payload at cycle pulse_at.
   task automatic run_frame(input int unsigned bc, input logic [7:0] c, input logic [3:0] a,
                            input int unsigned pulse_at, input string tag);
      logic [14:0] exp;
      int unsigned bit_i;
      exp  = frame_bits(c, a);
      sel4 = (bc == 4);
      wait_ready(tag);
      drv_cmd   = c;
      drv_addr  = a;
      drv_valid = 1'b1;
      for (int unsigned cyc = 1; cyc <= 15 * bc; cyc++) begin
         @(negedge clk);
         if (cyc == 1) drv_valid = 1'b0;
         if (pulse_at != 0 && cyc == pulse_at) begin
            drv_valid = 1'b1;
            drv_cmd   = ~c;
            drv_addr  = ~a;
         end
         if (pulse_at != 0 && cyc == pulse_at + 1) drv_valid = 1'b0;
         bit_i = (cyc - 1) / bc;
         checks++;
         if (tx_o !== exp[bit_i]) begin
            failures++;
            $display("FAIL %s_tx cyc=%0d: tx_out=%b required %b", tag, cyc, tx_o, exp[bit_i]);
         end
         checks++;
         if (done_o !== (cyc == 15 * bc)) begin
            failures++;
            $display("FAIL %s_done cyc=%0d: done=%b required %b", tag, cyc, done_o, (cyc == 15 * bc));
         end
         checks++;
         if ({busy_o, rdy_o} !== 2'b10) begin
            failures++;
            $display("FAIL %s_status cyc=%0d: busy/ready=%b required 10", tag, cyc, {busy_o, rdy_o});
         end
      end
      for (int unsigned g = 0; g < bc; g++) begin
         @(negedge clk);
         checks++;
         if ({tx_o, done_o, busy_o, rdy_o} !== 4'b1010) begin
            failures++;
            $display("FAIL %s_gap g=%0d: tx/done/busy/rdy=%b required 1010", tag, g, {tx_o, done_o, busy_o, rdy_o});
         end
      end
      @(negedge clk);
      checks++;
      if ({tx_o, done_o, busy_o, rdy_o} !== 4'b1001) begin
         failures++;
         $display("FAIL %s_idle: tx/done/busy/rdy=%b required 1001", tag, {tx_o, done_o, busy_o, rdy_o});
      end
   endtask

   task automatic test_frame_bc1;
      logic [14:0] hand;
      hand = 15'b110011101001010;
      checks++;
      if (frame_bits(8'hA5, 4'h3) !== hand) begin
         failures++;
         $display("FAIL frame_table: model=%b required %b", frame_bits(8'hA5, 4'h3), hand);
      end
      run_frame(1, 8'hA5, 4'h3, 0, "bc1_a5");
   endtask

   task automatic test_frame_bc4;
      run_frame(4, 8'hA5, 4'h3, 0, "bc4_a5");
   endtask

   task automatic test_back_to_back;
      logic [14:0] e1, e2;
      logic        exp_tx;
      e1 = frame_bits(8'h01, 4'h1);
      e2 = frame_bits(8'hFF, 4'h0);
      sel4 = 1'b0;
      wait_ready("b2b");
      drv_cmd   = 8'h01;
      drv_addr  = 4'h1;
      drv_valid = 1'b1;
      for (int unsigned cyc = 1; cyc <= 32; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin
            drv_cmd  = 8'hFF;
            drv_addr = 4'h0;
         end
         if (cyc == 18) drv_valid = 1'b0;
         if (cyc <= 15)      exp_tx = e1[cyc - 1];
         else if (cyc <= 17) exp_tx = 1'b1;
         else                exp_tx = e2[cyc - 18];
         checks++;
         if (tx_o !== exp_tx) begin
            failures++;
            $display("FAIL b2b_tx cyc=%0d: tx_out=%b required %b", cyc, tx_o, exp_tx);
         end
         checks++;
         if (done_o !== (cyc == 15 || cyc == 32)) begin
            failures++;
            $display("FAIL b2b_done cyc=%0d: done=%b required %b", cyc, done_o, (cyc == 15 || cyc == 32));
         end
         checks++;
         if ({busy_o, rdy_o} !== ((cyc == 17) ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL b2b_status cyc=%0d: busy/ready=%b required %b", cyc, {busy_o, rdy_o},
                     (cyc == 17) ? 2'b01 : 2'b10);
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, rdy_o} !== 2'b01) begin
         failures++;
         $display("FAIL b2b_final_idle: busy/ready=%b required 01", {busy_o, rdy_o});
      end
   endtask

   task automatic test_reset_abort;
      sel4 = 1'b0;
      wait_ready("abort");
      drv_cmd   = 8'h00;
      drv_addr  = 4'hF;
      drv_valid = 1'b1;
      for (int unsigned cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         if (cyc == 1) drv_valid = 1'b0;
      end
      checks++;
      if ({tx_o, busy_o} !== 2'b01) begin
         failures++;
         $display("FAIL abort_pre: tx/busy=%b required 01", {tx_o, busy_o});
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({tx1, busy1, done1, rdy1} !== 4'b1000) begin
         failures++;
         $display("FAIL abort_async: tx/busy/done/rdy=%b required 1000", {tx1, busy1, done1, rdy1});
      end
      @(negedge clk);
      checks++;
      if ({tx1, busy1, done1, rdy1} !== 4'b1000) begin
         failures++;
         $display("FAIL abort_held: tx/busy/done/rdy=%b required 1000", {tx1, busy1, done1, rdy1});
      end
      rst = 1'b1;
      for (int unsigned k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({tx_o, done_o, busy_o} !== 3'b100) begin
            failures++;
            $display("FAIL abort_quiet k=%0d: tx/done/busy=%b required 100", k, {tx_o, done_o, busy_o});
         end
      end
      run_frame(1, 8'hA5, 4'h3, 0, "after_abort");
   endtask

   task automatic test_ignore_midframe;
      run_frame(4, 8'h3C, 4'h5, 10, "ignore");
   endtask

   // Independent line receiver: find SOP, sample each bit mid-period, rebuild fields.
   task automatic test_loopback;
      logic [7:0]  c;
      logic [3:0]  a;
      logic [14:0] rx;
      int unsigned n;
      sel4 = 1'b1;
      for (int f = 0; f < 100; f++) begin
         c = 8'($urandom);
         a = 4'($urandom);
         rx = '0;
         wait_ready("loopback");
         drv_cmd   = c;
         drv_addr  = a;
         drv_valid = 1'b1;
         @(negedge clk);
         drv_valid = 1'b0;
         n = 0;
         while (tx_o !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         @(negedge clk);
         for (int k = 0; k < 15; k++) begin
            rx[k] = tx_o;
            repeat (4) @(negedge clk);
         end
         checks++;
         if ({rx[0], rx[14:13]} !== 3'b011) begin
            failures++;
            $display("FAIL loop_framing f=%0d: sop/eof=%b required 011", f, {rx[0], rx[14:13]});
         end
         checks++;
         if (rx[8:1] !== c) begin
            failures++;
            $display("FAIL loop_cmd f=%0d: decoded=%h required %h", f, rx[8:1], c);
         end
         checks++;
         if (rx[12:9] !== a) begin
            failures++;
            $display("FAIL loop_addr f=%0d: decoded=%h required %h", f, rx[12:9], a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame_bc1();
      test_frame_bc4();
      test_back_to_back();
      test_reset_abort();
      test_ignore_midframe();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
